ws2812_rx: RTL and testbench

Single-wire WS2812 NRZ receiver and decoder: the pixel end of the GRB stream that our LED shipping logic transmits. It recovers the first 24 bits of each frame into a GRB word, passes all later bits downstream on `dout`, and latches the word when the line has been low for the reset gap. It serves as a chain element for simulated pixel strings and as a loopback checker for the transmitter.

---
 rtl/ws2812_rx.sv | 196 +++++++++++++++++++
 tb/tb_ws2812_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 NRZ pixel receiver: decodes the first 24 bits of a frame into a GRB word,
// forwards every later bit on dout, and latches the word after the line-low reset gap.
module ws2812_rx #(
  parameter int THRESH_CYC  = 30,
  parameter int MAXHIGH_CYC = 75,
  parameter int RESET_CYC   = 2500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic        dout,
  output logic [23:0] grb,
  output logic        grb_valid,
  output logic        busy,
  output logic        err
);

  localparam int HW = $clog2(MAXHIGH_CYC + 1);
  localparam int LW = $clog2(RESET_CYC + 1);

  localparam logic [HW-1:0] HCNT_MAX = HW'(MAXHIGH_CYC);
  localparam logic [HW-1:0] HCNT_THR = HW'(THRESH_CYC);
  localparam logic [LW-1:0] LCNT_MAX = LW'(RESET_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          din_s_q, din_s_d;
  logic          prev_q, prev_d;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [23:0]   shreg_q, shreg_d;
  logic          fwd_q, fwd_d;
  logic [23:0]   grb_q, grb_d;
  logic          grb_valid_q, grb_valid_d;
  logic          err_q, err_d;
  logic          dout_q, dout_d;

  logic          rise, fall, bit_val;
  logic [HW-1:0] hcnt_inc;
  logic [LW-1:0] lcnt_inc;

  // Synchronizer and edge detect. A line that is already high when reset releases
  // must not look like a rising edge, so edges are only honoured once din_s has
  // been genuinely observed low after the synchronizer has refilled.
  always_comb begin
    sync1_d = din;
    din_s_d = sync1_q;
    prev_d  = din_s_q;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ((fill_q == 2'd2) & ~din_s_q);
  end

  assign rise     = din_s_q & ~prev_q & armed_q;
  assign fall     = ~din_s_q & prev_q;
  assign bit_val  = (hcnt_q >= HCNT_THR);
  assign hcnt_inc = (hcnt_q >= HCNT_MAX) ? HCNT_MAX : hcnt_q + 1'b1;
  assign lcnt_inc = (lcnt_q >= LCNT_MAX) ? LCNT_MAX : lcnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    fwd_d       = fwd_q;
    grb_d       = grb_q;
    grb_valid_d = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HIGH;
          hcnt_d  = HW'(1);
        end
      end

      S_HIGH: begin
        // Over-long pulse: the frame is dropped at once so nothing more is forwarded.
        if ((fall && hcnt_q >= HCNT_MAX) || (!fall && hcnt_inc == HCNT_MAX)) begin
          err_d    = 1'b1;
          state_d  = S_ERR;
          hcnt_d   = '0;
          lcnt_d   = '0;
          bitcnt_d = '0;
          shreg_d  = '0;
          fwd_d    = 1'b0;
        end else if (fall) begin
          if (bitcnt_q < 5'd24) begin
            shreg_d  = {shreg_q[22:0], bit_val};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd23) fwd_d = 1'b1;
          end
          state_d = S_LOW;
          lcnt_d  = LW'(1);
        end else begin
          hcnt_d = hcnt_inc;
        end
      end

      S_LOW: begin
        // A rising edge beats the reset-gap expiry in the same cycle.
        if (rise) begin
          state_d = S_HIGH;
          hcnt_d  = HW'(1);
        end else if (lcnt_inc == LCNT_MAX) begin
          if (bitcnt_q == 5'd24) begin
            grb_d       = shreg_q;
            grb_valid_d = 1'b1;
          end else if (bitcnt_q != 5'd0) begin
            err_d = 1'b1;
          end
          state_d  = S_IDLE;
          hcnt_d   = '0;
          lcnt_d   = '0;
          bitcnt_d = '0;
          shreg_d  = '0;
          fwd_d    = 1'b0;
        end else begin
          lcnt_d = lcnt_inc;
        end
      end

      S_ERR: begin
        if (din_s_q) begin
          lcnt_d = '0;
        end else if (lcnt_inc == LCNT_MAX) begin
          state_d  = S_IDLE;
          lcnt_d   = '0;
          bitcnt_d = '0;
          shreg_d  = '0;
          fwd_d    = 1'b0;
        end else begin
          lcnt_d = lcnt_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase

    dout_d = din_s_q & fwd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      din_s_q     <= 1'b0;
      prev_q      <= 1'b0;
      fill_q      <= 2'd0;
      armed_q     <= 1'b0;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      fwd_q       <= 1'b0;
      grb_q       <= '0;
      grb_valid_q <= 1'b0;
      err_q       <= 1'b0;
      dout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      din_s_q     <= din_s_d;
      prev_q      <= prev_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      fwd_q       <= fwd_d;
      grb_q       <= grb_d;
      grb_valid_q <= grb_valid_d;
      err_q       <= err_d;
      dout_q      <= dout_d;
    end
  end

  assign dout      = dout_q;
  assign grb       = grb_q;
  assign grb_valid = grb_valid_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: frames, threshold boundary, short frame,
// stuck-high recovery, mid-frame reset, and a cycle-exact dout stream model.
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic        dout;
  logic [23:0] grb;
  logic        grb_valid;
  logic        busy;
  logic        err;

  ws2812_rx dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .dout      (dout),
    .grb       (grb),
    .grb_valid (grb_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected dout = (din & fwd_flag) delayed three clocks.
  logic       fwd_flag = 1'b0;
  logic [2:0] din_pipe = 3'b000;
  logic       mon_en   = 1'b0;
  logic       dout_prev = 1'b0;
  int         vcount = 0, ecount = 0, dout_bad = 0, dout_rises = 0;

  always @(posedge clk) din_pipe <= {din_pipe[1:0], din & fwd_flag};

  always @(negedge clk) begin
    if (mon_en) begin
      if (grb_valid) vcount <= vcount + 1;
      if (err) ecount <= ecount + 1;
      if (dout !== din_pipe[2]) dout_bad <= dout_bad + 1;
      if (dout && !dout_prev) dout_rises <= dout_rises + 1;
      dout_prev <= dout;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) tick();
  endtask

  // MSB-first bits of w; period fixed at 62 cycles.
  task automatic send_frame(input logic [23:0] w, input int nbits, input int h1, input int h0);
    for (int i = 0; i < nbits; i++) begin
      int h;
      h = w[23 - i] ? h1 : h0;
      din = 1'b1;
      repeat (h) tick();
      din = 1'b0;
      repeat (62 - h) tick();
    end
  endtask

  int v0, e0, r0;

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_grb", grb, 24'h0);
    check("rst_valid", grb_valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    tick();

    // Frame 0xFF0000
    v0 = vcount; e0 = ecount;
    send_frame(24'hFF0000, 24, 40, 20);
    check("t1_busy_mid", busy, 1);
    gap(2600);
    check("t1_grb", grb, 24'hFF0000);
    check("t1_valid_cnt", vcount - v0, 1);
    check("t1_err_cnt", ecount - e0, 0);
    check("t1_busy_end", busy, 0);
    check("t1_dout_stream", dout_bad, 0);

    // 48 bits: latch first word, forward second
    v0 = vcount; r0 = dout_rises;
    send_frame(24'h00FF00, 24, 40, 20);
    fwd_flag = 1'b1;
    send_frame(24'h0000FF, 24, 40, 20);
    fwd_flag = 1'b0;
    gap(2600);
    check("t2_grb", grb, 24'h00FF00);
    check("t2_valid_cnt", vcount - v0, 1);
    check("t2_dout_pulses", dout_rises - r0, 24);
    check("t2_dout_stream", dout_bad, 0);

    // Threshold boundary 29/30 cycles
    v0 = vcount;
    send_frame(24'h555555, 24, 30, 29);
    gap(2600);
    check("t3_grb", grb, 24'h555555);
    check("t3_valid_cnt", vcount - v0, 1);

    // Short frame: 12 bits
    v0 = vcount; e0 = ecount;
    send_frame(24'hABC000, 12, 40, 20);
    gap(2600);
    check("t4_err_cnt", ecount - e0, 1);
    check("t4_valid_cnt", vcount - v0, 0);
    check("t4_grb_kept", grb, 24'h555555);

    // Stuck high, then recovery
    e0 = ecount; v0 = vcount;
    din = 1'b1;
    repeat (100) tick();
    check("t5_err_cnt", ecount - e0, 1);
    check("t5_busy_err", busy, 1);
    check("t5_dout_err", dout, 0);
    gap(2600);
    check("t5_busy_idle", busy, 0);
    send_frame(24'h123456, 24, 40, 20);
    gap(2600);
    check("t5_grb", grb, 24'h123456);
    check("t5_valid_cnt", vcount - v0, 1);
    check("t5_err_total", ecount - e0, 1);

    // Reset after 10 bits
    send_frame(24'hFFFFFF, 10, 40, 20);
    din   = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_grb", grb, 24'h0);
    check("t6_valid", grb_valid, 0);
    check("t6_err", err, 0);
    check("t6_busy", busy, 0);
    check("t6_dout", dout, 0);
    tick();
    gap(50);
    v0 = vcount; e0 = ecount;
    send_frame(24'hA5A5A5, 24, 40, 20);
    gap(2600);
    check("t6_grb_after", grb, 24'hA5A5A5);
    check("t6_valid_cnt", vcount - v0, 1);
    check("t6_err_cnt", ecount - e0, 0);
    check("final_dout_stream", dout_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
